// File: rtl/arbiter_4_req_ctrl.sv
// Clocked 4-phase request/release front-end for a 4-way mutex arbiter: Y synchronisers, per-channel FSMs, overlap flag.
// Optional per-channel grant hold timeout is built in when ARB4_REQ_CTRL_TIMEOUT_EN is defined.
module arbiter_4_req_ctrl #(
   parameter int          SYNC_STAGES = 2,
   parameter int unsigned HOLD_MAX    = 255
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] REQ,
   input  logic [3:0] REL,
   output logic [3:0] X,
   input  logic [3:0] Y,
   output logic [3:0] GNT,
   output logic       OVLP,
   output logic [3:0] TOUT
);

   typedef enum logic [1:0] {IDLE, WAIT, HELD, DROP} state_e;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || HOLD_MAX > 255) begin : g_bad_params
      $error("arbiter_4_req_ctrl: SYNC_STAGES must be 2..3 and HOLD_MAX must fit in 8 bits");
   end

   logic [3:0] sync_q [SYNC_STAGES];
   logic [3:0] ysync;
   logic       ovlp_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 4'h0;
         ovlp_q <= 1'b0;
      end else begin
         sync_q[0] <= Y;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         ovlp_q <= ($countones(ysync) > 1);
      end
   end

   assign ysync = sync_q[SYNC_STAGES-1];
   assign OVLP  = ovlp_q;

   for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      state_e state_q, state_d;
      logic   x_q, x_d, gnt_q, gnt_d;
      logic   timeout_hit;

`ifdef ARB4_REQ_CTRL_TIMEOUT_EN
      localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);
      logic [7:0] cnt_q, cnt_d;
      logic       tout_q, tout_d;

      // Counter reads zero on the first HELD cycle, so the grant lasts HOLD_MAX+1 cycles.
      always_comb begin
         cnt_d       = (state_q == HELD) ? cnt_q + 8'd1 : 8'd0;
         timeout_hit = (state_q == HELD) && (cnt_q == HOLD_LIMIT);
         tout_d      = tout_q | (timeout_hit & ~REL[gi]);
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            cnt_q  <= 8'd0;
            tout_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
         end
      end

      assign TOUT[gi] = tout_q;
`else
      assign timeout_hit = 1'b0;
      assign TOUT[gi]    = 1'b0;
`endif

      always_ff @(posedge CLK) begin
         if (RST) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            gnt_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            x_q     <= x_d;
            gnt_q   <= gnt_d;
         end
      end

      always_comb begin
         state_d = state_q;
         unique case (state_q)
            IDLE: if (REQ[gi]) state_d = WAIT;
            WAIT: begin
               // A withdrawn request wins over a grant arriving in the same cycle.
               if (!REQ[gi])       state_d = DROP;
               else if (ysync[gi]) state_d = HELD;
            end
            HELD: if (REL[gi] || timeout_hit) state_d = DROP;
            DROP: if (!ysync[gi]) state_d = IDLE;
         endcase
      end

      // Outputs decoded from the next state so X/GNT come straight from flops.
      always_comb begin
         x_d   = (state_d == WAIT) || (state_d == HELD);
         gnt_d = (state_d == HELD);
      end

      assign X[gi]   = x_q;
      assign GNT[gi] = gnt_q;
   end

endmodule

// File: tb/tb_arbiter_4_req_ctrl.sv
// Bench for arbiter_4_req_ctrl with a behavioural mutex model driving Y; honours ARB4_REQ_CTRL_TIMEOUT_EN.
module tb_arbiter_4_req_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] REQ = 4'h0;
   logic [3:0] REL = 4'h0;
   logic [3:0] X, Y, GNT, TOUT;
   logic       OVLP;

   arbiter_4_req_ctrl #(.SYNC_STAGES(2), .HOLD_MAX(10)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .REL(REL), .X(X),
      .Y(Y), .GNT(GNT), .OVLP(OVLP), .TOUT(TOUT)
   );

   always #5 CLK = ~CLK;

   // Mutex model: owner keeps Y until its X falls; a free mutex goes to the lowest requester.
   int         owner  = -1;
   logic       ovr_en = 1'b0;
   logic [3:0] ovr_y  = 4'h0;

   always @(X) begin
      if (owner >= 0 && !X[owner]) owner = -1;
      if (owner < 0)
         for (int i = 0; i < 4; i++)
            if (X[i] && owner < 0) owner = i;
   end

   assign Y = ovr_en ? ovr_y : ((owner >= 0) ? 4'(1 << owner) : 4'h0);

   typedef struct {
      logic [3:0] req, rel, x, gnt;
   } vec_t;

   typedef struct {
      string      nm;
      logic [3:0] x, gnt, tout;
      logic       ovlp;
   } exp_t;

   vec_t tbl [18];
   exp_t sb [$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic step(input string nm, input logic rst_v, input logic [3:0] req_v,
                       input logic [3:0] rel_v, input logic [3:0] x_e, input logic [3:0] g_e,
                       input logic o_e = 1'b0, input logic [3:0] t_e = 4'h0);
      exp_t e;
      e.nm = nm; e.x = x_e; e.gnt = g_e; e.ovlp = o_e; e.tout = t_e;
      sb.push_back(e);
      RST = rst_v; REQ = req_v; REL = rel_v;
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      $display("%0t %s: RST=%b REQ=%h REL=%h -> X=%h GNT=%h OVLP=%b TOUT=%h",
               $time, e.nm, rst_v, req_v, rel_v, X, GNT, OVLP, TOUT);
      chk({e.nm, ".X"},    X,           e.x);
      chk({e.nm, ".GNT"},  GNT,         e.gnt);
      chk({e.nm, ".OVLP"}, {3'b0, OVLP}, {3'b0, e.ovlp});
      chk({e.nm, ".TOUT"}, TOUT,        e.tout);
      REL = 4'h0;
   endtask

   task automatic idle(input string nm, input int n);
      for (int k = 0; k < n; k++) step(nm, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [3:0] mask;
      string      nm;

      // Single request on channel 0: grant 3 edges after sample, re-request 4 edges after REL.
      tbl[0]  = '{4'h1, 4'h0, 4'h1, 4'h0};
      tbl[1]  = '{4'h1, 4'h0, 4'h1, 4'h0};
      tbl[2]  = '{4'h1, 4'h0, 4'h1, 4'h0};
      tbl[3]  = '{4'h1, 4'h0, 4'h1, 4'h1};
      tbl[4]  = '{4'h0, 4'h0, 4'h1, 4'h1};
      tbl[5]  = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[6]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[7]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[8]  = '{4'h1, 4'h0, 4'h0, 4'h0};
      tbl[9]  = '{4'h1, 4'h0, 4'h1, 4'h0};
      tbl[10] = '{4'h1, 4'h1, 4'h1, 4'h0};
      tbl[11] = '{4'h1, 4'h0, 4'h1, 4'h0};
      tbl[12] = '{4'h1, 4'h0, 4'h1, 4'h1};
      tbl[13] = '{4'h0, 4'h1, 4'h0, 4'h0};
      tbl[14] = '{4'h0, 4'h0, 4'h0, 4'h0};
      tbl[15] = '{4'h0, 4'h0, 4'h0, 4'h0};
      tbl[16] = '{4'h0, 4'h0, 4'h0, 4'h0};
      tbl[17] = '{4'h0, 4'h1, 4'h0, 4'h0};

      step("reset0", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
      step("reset1", 1'b1, 4'hF, 4'hF, 4'h0, 4'h0);

      for (int k = 0; k < 18; k++)
         step($sformatf("single[%0d]", k), 1'b0, tbl[k].req, tbl[k].rel, tbl[k].x, tbl[k].gnt);

      // Contention: all four request together, grants handed on in mutex order.
      mask = 4'hF;
      for (int k = 0; k < 3; k++) step($sformatf("cont.w%0d", k), 1'b0, mask, 4'h0, mask, 4'h0);
      step("cont.g0", 1'b0, mask, 4'h0, mask, 4'h1);
      for (int k = 0; k < 4; k++) begin
         mask = mask & ~4'(1 << k);
         step($sformatf("cont.rel%0d", k), 1'b0, mask, 4'(1 << k), mask, 4'h0);
         if (mask != 4'h0) begin
            step($sformatf("cont.h%0da", k), 1'b0, mask, 4'h0, mask, 4'h0);
            step($sformatf("cont.h%0db", k), 1'b0, mask, 4'h0, mask, 4'h0);
            step($sformatf("cont.g%0d", k + 1), 1'b0, mask, 4'h0, mask, 4'(1 << (k + 1)));
         end
      end
      idle("cont.idle", 4);

      // Withdrawal of channel 2 while channel 3 holds the grant.
      for (int k = 0; k < 3; k++) step("wd.w", 1'b0, 4'h8, 4'h0, 4'h8, 4'h0);
      step("wd.g3", 1'b0, 4'h8, 4'h0, 4'h8, 4'h8);
      step("wd.req2", 1'b0, 4'hC, 4'h0, 4'hC, 4'h8);
      step("wd.drop2", 1'b0, 4'h8, 4'h0, 4'h8, 4'h8);
      step("wd.hold_a", 1'b0, 4'h8, 4'h0, 4'h8, 4'h8);
      step("wd.hold_b", 1'b0, 4'h8, 4'h0, 4'h8, 4'h8);
      step("wd.rel3", 1'b0, 4'h0, 4'h8, 4'h0, 4'h0);
      idle("wd.idle", 3);

      // Reset in the middle of a grant, then a normal grant afterwards.
      for (int k = 0; k < 3; k++) step("rst.w", 1'b0, 4'h4, 4'h0, 4'h4, 4'h0);
      step("rst.g2", 1'b0, 4'h4, 4'h0, 4'h4, 4'h4);
      step("rst.mid", 1'b1, 4'h4, 4'h0, 4'h0, 4'h0);
      for (int k = 0; k < 3; k++) step("rst.rew", 1'b0, 4'h4, 4'h0, 4'h4, 4'h0);
      step("rst.reg2", 1'b0, 4'h4, 4'h0, 4'h4, 4'h4);
      step("rst.rel", 1'b0, 4'h0, 4'h4, 4'h0, 4'h0);
      idle("rst.idle", 3);

      // Hold timeout on channel 1 with HOLD_MAX=10.
      for (int k = 0; k < 3; k++) step("to.w", 1'b0, 4'h2, 4'h0, 4'h2, 4'h0);
      step("to.held0", 1'b0, 4'h2, 4'h0, 4'h2, 4'h2);
      for (int k = 1; k <= 10; k++)
         step($sformatf("to.held%0d", k), 1'b0, 4'h0, 4'h0, 4'h2, 4'h2);
`ifdef ARB4_REQ_CTRL_TIMEOUT_EN
      step("to.expire", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h2);
      for (int k = 0; k < 4; k++) step("to.sticky", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h2);
      step("to.clear", 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
      // REL landing on the timeout cycle is a plain release.
      for (int k = 0; k < 3; k++) step("torel.w", 1'b0, 4'h2, 4'h0, 4'h2, 4'h0);
      step("torel.held0", 1'b0, 4'h2, 4'h0, 4'h2, 4'h2);
      for (int k = 1; k <= 10; k++)
         step($sformatf("torel.held%0d", k), 1'b0, 4'h0, 4'h0, 4'h2, 4'h2);
      step("torel.rel", 1'b0, 4'h0, 4'h2, 4'h0, 4'h0);
`else
      for (int k = 11; k < 16; k++)
         step($sformatf("to.held%0d", k), 1'b0, 4'h0, 4'h0, 4'h2, 4'h2);
      step("to.rel", 1'b0, 4'h0, 4'h2, 4'h0, 4'h0);
`endif
      idle("to.idle", 3);

      // Overlap diagnostic: one-cycle forced Y=0011.
      ovr_y  = 4'h3;
      ovr_en = 1'b1;
      step("ovlp.e0", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      ovr_en = 1'b0;
      step("ovlp.e1", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      step("ovlp.e2", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      step("ovlp.e3", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

      nm = "";
      $display("Result: errors=%0d of %0d checks%s", n_err, n_checks, nm);
      $finish;
   end

endmodule
